// File: rtl/parity_frame_checker.sv
// Streaming parity generator/checker: XOR-accumulates multi-word frames, checks
// a transmitted parity bit against per-frame even/odd mode, reports per frame.
module parity_frame_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_par,
  input  logic             odd_mode,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_error,
  output logic [CNT_W-1:0] out_len,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_err,
  output logic             led
);

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] REPORT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       state;
  logic             acc;
  logic [CNT_W-1:0] len;
  logic             mode_q;

  logic             xfer;
  logic             first;
  logic             mode_eff;
  logic             acc_next;
  logic [CNT_W-1:0] len_next;
  logic             frame_err;
  logic             err_event;

  assign in_ready = (state == ACCUM);
  assign xfer     = in_valid && in_ready;

  // len only returns to zero at frame end, so it saturating never fakes a frame start
  assign first     = (len == '0);
  assign mode_eff  = first ? odd_mode : mode_q;
  assign acc_next  = acc ^ (^in_data);
  assign len_next  = (len == CNT_MAX) ? len : len + 1'b1;
  assign frame_err = ((acc_next ^ in_par) != mode_eff);
  assign err_event = xfer && in_last && frame_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      acc        <= 1'b0;
      len        <= '0;
      mode_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_error  <= 1'b0;
      out_len    <= '0;
    end else if (xfer) begin
      if (in_last) begin
        acc        <= 1'b0;
        len        <= '0;
        out_parity <= acc_next;
        out_error  <= frame_err;
        out_len    <= len_next;
        out_valid  <= 1'b1;
        state      <= REPORT;
      end else begin
        acc <= acc_next;
        len <= len_next;
        if (first) mode_q <= odd_mode;
      end
    end else if (state == REPORT && out_ready) begin
      out_valid <= 1'b0;
      state     <= ACCUM;
    end
  end

  // An errored frame landing on the same edge as clr_err counts as the first error after the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      led       <= 1'b0;
    end else if (err_event) begin
      err_count <= clr_err ? {{(CNT_W-1){1'b0}}, 1'b1}
                           : ((err_count == CNT_MAX) ? err_count : err_count + 1'b1);
      led       <= 1'b1;
    end else if (clr_err) begin
      err_count <= '0;
      led       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench for parity_frame_checker: directed and random frames
// compared against a counting-based reference model.
module tb_parity_frame_checker;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0, in_last = 1'b0, in_par = 1'b0, odd_mode = 1'b0;
  logic          in_ready, out_valid, out_parity, out_error, led;
  logic          out_ready = 1'b0, clr_err = 1'b0;
  logic [CW-1:0] out_len, err_count;

  int total  = 0;
  int passed = 0;

  // reference model state
  int exp_cnt = 0;
  bit exp_led = 1'b0;
  bit exp_par, exp_err;
  int exp_len;
  logic [W-1:0] frame_q[$];

  parity_frame_checker #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_par(in_par), .odd_mode(odd_mode),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_parity(out_parity), .out_error(out_error), .out_len(out_len),
    .err_count(err_count), .clr_err(clr_err), .led(led)
  );

  always #5 clk = ~clk;

  // Called at a negedge; leaves the word driven across the accepting posedge.
  task automatic push_word(input logic [W-1:0] w, input bit last, input bit par, input bit mode);
    int t = 0;
    in_valid = 1'b1; in_data = w; in_last = last; in_par = par; odd_mode = mode;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin
      total++;
      $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends frame_q; odd_mode is inverted after the first word to prove it is latched.
  task automatic run_frame(input bit odd, input bit par, input bit clr_on_last);
    int ones = 0;
    int n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      ones += $countones(frame_q[i]);
      if (i == n - 1) clr_err = clr_on_last;
      push_word(frame_q[i], i == n - 1, par, (i == 0) ? odd : ~odd);
    end
    in_valid = 1'b0; in_last = 1'b0; clr_err = 1'b0;
    exp_par = (ones % 2) == 1;
    exp_err = (((ones + int'(par)) % 2) == 1) != odd;
    exp_len = (n > CMAX) ? CMAX : n;
    if (exp_err) begin
      exp_cnt = clr_on_last ? 1 : ((exp_cnt >= CMAX) ? CMAX : exp_cnt + 1);
      exp_led = 1'b1;
    end else if (clr_on_last) begin
      exp_cnt = 0;
      exp_led = 1'b0;
    end
    total++; if (out_valid !== 1'b1) $display("FAIL res_valid got=%0b exp=1", out_valid); else passed++;
    total++; if (out_parity !== exp_par) $display("FAIL res_parity got=%0b exp=%0b", out_parity, exp_par); else passed++;
    total++; if (out_error !== exp_err) $display("FAIL res_error got=%0b exp=%0b", out_error, exp_err); else passed++;
    total++; if (out_len !== CW'(exp_len)) $display("FAIL res_len got=%0d exp=%0d", out_len, exp_len); else passed++;
    total++; if (err_count !== CW'(exp_cnt)) $display("FAIL res_err_count got=%0d exp=%0d", err_count, exp_cnt); else passed++;
    total++; if (led !== exp_led) $display("FAIL res_led got=%0b exp=%0b", led, exp_led); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL res_in_ready got=%0b exp=0", in_ready); else passed++;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL take_valid got=%0b exp=0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL take_in_ready got=%0b exp=1", in_ready); else passed++;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_word(4'hF, 1'b0, 1'b0, 1'b1);
    push_word(4'h3, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_parity, out_error, out_len, err_count, led} !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_outputs got=%b/%0b exp=0/1",
               {out_valid, out_parity, out_error, out_len, err_count, led}, in_ready);
    else passed++;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0; exp_led = 1'b0;
    frame_q = '{4'b0001};
    run_frame(1'b1, 1'b0, 1'b0);
    take_result();
  endtask

  task automatic test_single_word();
    frame_q = '{4'b0111};
    run_frame(1'b1, 1'b0, 1'b0);
    take_result();
    run_frame(1'b1, 1'b1, 1'b0);
    total++; if (err_count !== 8'd1 || led !== 1'b1)
      $display("FAIL single_err got=%0d/%0b exp=1/1", err_count, led); else passed++;
    take_result();
  endtask

  task automatic test_multi_word();
    frame_q = '{4'h1, 4'h3, 4'hF};
    run_frame(1'b0, 1'b1, 1'b0);
    total++; if (out_error !== 1'b0 || out_len !== 8'd3)
      $display("FAIL multi_ok got=%0b/%0d exp=0/3", out_error, out_len); else passed++;
    take_result();
    run_frame(1'b0, 1'b0, 1'b0);
    total++; if (out_error !== 1'b1)
      $display("FAIL multi_err got=%0b exp=1", out_error); else passed++;
    take_result();
  endtask

  task automatic test_backpressure();
    logic [CW+1:0] snap;
    frame_q = '{4'h6, 4'h5};
    run_frame(1'b1, 1'b1, 1'b0);
    snap = {out_parity, out_error, out_len};
    in_valid = 1'b1; in_data = 4'h9; in_last = 1'b0; in_par = 1'b0; odd_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_parity, out_error, out_len} !== snap)
        $display("FAIL bp_hold cyc=%0d got=%0b/%0b/%h exp=1/0/%h",
                 i, out_valid, in_ready, {out_parity, out_error, out_len}, snap);
      else passed++;
    end
    in_valid = 1'b0;
    take_result();
    frame_q = '{4'hA};
    run_frame(1'b0, 1'b0, 1'b0);
    take_result();
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      int n = $urandom_range(1, 6);
      frame_q = {};
      for (int i = 0; i < n; i++) frame_q.push_back(W'($urandom));
      run_frame(1'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      take_result();
    end
  endtask

  task automatic test_saturation();
    frame_q = {};
    for (int i = 0; i < 300; i++) frame_q.push_back(W'($urandom));
    run_frame(1'b1, 1'($urandom), 1'b0);
    total++; if (out_len !== 8'd255)
      $display("FAIL sat_len got=%0d exp=255", out_len); else passed++;
    take_result();
    for (int f = 0; f < 260; f++) begin
      logic [W-1:0] w = W'($urandom);
      bit m = 1'($urandom);
      // choose the check bit that makes the frame fail
      bit p = ((($countones(w) % 2) == 1) ^ m) ^ 1'b1;
      frame_q = '{w};
      run_frame(m, p, 1'b0);
      take_result();
    end
    total++; if (err_count !== 8'd255 || led !== 1'b1)
      $display("FAIL sat_err_count got=%0d/%0b exp=255/1", err_count, led); else passed++;
  endtask

  task automatic test_clear();
    frame_q = '{4'b0011};
    run_frame(1'b1, 1'b0, 1'b1);
    total++; if (err_count !== 8'd1 || led !== 1'b1)
      $display("FAIL clr_coincident got=%0d/%0b exp=1/1", err_count, led); else passed++;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    exp_cnt = 0; exp_led = 1'b0;
    total++; if (err_count !== 8'd0 || led !== 1'b0)
      $display("FAIL clr_alone got=%0d/%0b exp=0/0", err_count, led); else passed++;
    @(negedge clk);
    take_result();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_multi_word();
    test_backpressure();
    test_random();
    test_saturation();
    test_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
